// File: rtl/qslave2908.sv
// qslave2908: QBUS slave responder behind Am2908 transceivers.
// Decodes a small I/O-page register window and runs DATI, DATO(B) and DATIO(B) slave cycles.
module qslave2908 #(
    parameter logic [12:0] ADDR_BASE = 13'o12150,
    parameter int          REG_BITS  = 1,
    parameter int          READ_LAT  = 1
) (
    input  logic                clk,
    input  logic                RINIT_n,
    input  logic                RSYNC,
    input  logic                RDIN,
    input  logic                RDOUT,
    input  logic                RWTBT,
    input  logic                RBS7,
    input  logic [21:0]         RADDR,
    input  logic [15:0]         RDAL,
    input  logic                bus_master,
    output logic                TRPLY,
    output logic [15:0]         TDAL,
    output logic                assert_data,
    output logic                DALst,
    output logic                DALbe,
    output logic                selected,
    output logic [REG_BITS-1:0] reg_sel,
    output logic                reg_read,
    output logic                reg_write,
    input  logic [15:0]         reg_rdata,
    output logic [15:0]         reg_wdata,
    output logic [1:0]          reg_wbe,
    output logic [10:0]         fsm_state
);

    localparam int I_IDLE       = 0;
    localparam int I_DECODE     = 1;
    localparam int I_IGNORE     = 2;
    localparam int I_SELECTED   = 3;
    localparam int I_READ_FETCH = 4;
    localparam int I_READ_SETUP = 5;
    localparam int I_READ_DRIVE = 6;
    localparam int I_READ_RPLY  = 7;
    localparam int I_READ_HOLD  = 8;
    localparam int I_WRITE_RPLY = 9;
    localparam int I_WRITE_WAIT = 10;

    localparam logic [10:0] S_IDLE       = 11'b000_0000_0001;
    localparam logic [10:0] S_DECODE     = 11'b000_0000_0010;
    localparam logic [10:0] S_IGNORE     = 11'b000_0000_0100;
    localparam logic [10:0] S_SELECTED   = 11'b000_0000_1000;
    localparam logic [10:0] S_READ_FETCH = 11'b000_0001_0000;
    localparam logic [10:0] S_READ_SETUP = 11'b000_0010_0000;
    localparam logic [10:0] S_READ_DRIVE = 11'b000_0100_0000;
    localparam logic [10:0] S_READ_RPLY  = 11'b000_1000_0000;
    localparam logic [10:0] S_READ_HOLD  = 11'b001_0000_0000;
    localparam logic [10:0] S_WRITE_RPLY = 11'b010_0000_0000;
    localparam logic [10:0] S_WRITE_WAIT = 11'b100_0000_0000;

    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CW-1:0] FETCH_LAST = CW'(READ_LAT - 1);

    logic [1:0] sync_ff, din_ff, dout_ff, wtbt_ff;
    logic       s_rsync, s_rdin, s_rdout, s_rwtbt;
    logic [10:0] state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic       hit, abort, fetch_done;
    logic       trply_nxt, assert_nxt, dalst_nxt, dalbe_nxt, selected_nxt;
    logic       reg_read_nxt, reg_write_nxt;
    logic [15:0] tdal_nxt, wdata_nxt;
    logic [1:0] wbe_nxt;
    logic [REG_BITS-1:0] reg_sel_nxt;
    logic       unused_addr_hi;

    assign unused_addr_hi = ^RADDR[21:13];

    always_ff @(posedge clk or negedge RINIT_n) begin
        if (!RINIT_n) begin
            sync_ff <= '0;
            din_ff  <= '0;
            dout_ff <= '0;
            wtbt_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[0], RSYNC};
            din_ff  <= {din_ff[0], RDIN};
            dout_ff <= {dout_ff[0], RDOUT};
            wtbt_ff <= {wtbt_ff[0], RWTBT};
        end
    end

    assign s_rsync = sync_ff[1];
    assign s_rdin  = din_ff[1];
    assign s_rdout = dout_ff[1];
    assign s_rwtbt = wtbt_ff[1];

    assign hit        = RBS7 && (RADDR[12:REG_BITS+1] == ADDR_BASE[12:REG_BITS+1]);
    assign abort      = !s_rsync && !state[I_IDLE] && !state[I_IGNORE];
    assign fetch_done = (cnt == FETCH_LAST);
    assign fsm_state  = state;

    // State register; all bus-facing outputs are registered so they change only on clock edges.
    always_ff @(posedge clk or negedge RINIT_n) begin
        if (!RINIT_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            TRPLY       <= 1'b0;
            TDAL        <= '0;
            assert_data <= 1'b0;
            DALst       <= 1'b0;
            DALbe       <= 1'b0;
            selected    <= 1'b0;
            reg_sel     <= '0;
            reg_read    <= 1'b0;
            reg_write   <= 1'b0;
            reg_wdata   <= '0;
            reg_wbe     <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            TRPLY       <= trply_nxt;
            TDAL        <= tdal_nxt;
            assert_data <= assert_nxt;
            DALst       <= dalst_nxt;
            DALbe       <= dalbe_nxt;
            selected    <= selected_nxt;
            reg_sel     <= reg_sel_nxt;
            reg_read    <= reg_read_nxt;
            reg_write   <= reg_write_nxt;
            reg_wdata   <= wdata_nxt;
            reg_wbe     <= wbe_nxt;
        end
    end

    // Bus handshake: master holds SYNC for the whole cycle; each DIN/DOUT phase is answered by
    // raising RPLY and released when the master drops DIN/DOUT. Losing SYNC aborts from anywhere.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (1'b1)
                state[I_IDLE]:       if (s_rsync && !bus_master) state_nxt = S_DECODE;
                state[I_DECODE]:     state_nxt = hit ? S_SELECTED : S_IGNORE;
                state[I_IGNORE]:     if (!s_rsync) state_nxt = S_IDLE;
                state[I_SELECTED]: begin
                    if (s_rdin)       state_nxt = S_READ_FETCH;
                    else if (s_rdout) state_nxt = S_WRITE_RPLY;
                end
                state[I_READ_FETCH]: if (fetch_done) state_nxt = S_READ_SETUP;
                state[I_READ_SETUP]: state_nxt = S_READ_DRIVE;
                state[I_READ_DRIVE]: state_nxt = S_READ_RPLY;
                state[I_READ_RPLY]:  if (!s_rdin) state_nxt = S_READ_HOLD;
                state[I_READ_HOLD]:  state_nxt = S_SELECTED;
                state[I_WRITE_RPLY]: state_nxt = S_WRITE_WAIT;
                state[I_WRITE_WAIT]: if (!s_rdout) state_nxt = S_SELECTED;
                default:             state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_nxt       = cnt;
        trply_nxt     = TRPLY;
        tdal_nxt      = TDAL;
        assert_nxt    = assert_data;
        dalst_nxt     = DALst;
        dalbe_nxt     = DALbe;
        selected_nxt  = selected;
        reg_sel_nxt   = reg_sel;
        reg_read_nxt  = 1'b0;
        reg_write_nxt = 1'b0;
        wdata_nxt     = reg_wdata;
        wbe_nxt       = reg_wbe;
        if (abort) begin
            trply_nxt    = 1'b0;
            assert_nxt   = 1'b0;
            dalst_nxt    = 1'b0;
            dalbe_nxt    = 1'b0;
            selected_nxt = 1'b0;
        end else begin
            case (1'b1)
                state[I_DECODE]: begin
                    if (hit) begin
                        selected_nxt = 1'b1;
                        reg_sel_nxt  = RADDR[REG_BITS:1];
                    end
                end
                state[I_SELECTED]: begin
                    if (s_rdin) begin
                        reg_read_nxt = 1'b1;
                        cnt_nxt      = '0;
                    end else if (s_rdout) begin
                        reg_write_nxt = 1'b1;
                        wdata_nxt     = RDAL;
                        wbe_nxt       = s_rwtbt ? (RADDR[0] ? 2'b10 : 2'b01) : 2'b11;
                    end
                end
                state[I_READ_FETCH]: begin
                    if (fetch_done) begin
                        tdal_nxt   = reg_rdata;
                        assert_nxt = 1'b1;
                        dalst_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                state[I_READ_SETUP]: begin
                    dalst_nxt = 1'b0;
                    dalbe_nxt = 1'b1;
                end
                state[I_READ_DRIVE]: trply_nxt = 1'b1;
                state[I_READ_RPLY]:  if (!s_rdin) trply_nxt = 1'b0;
                state[I_READ_HOLD]: begin
                    dalbe_nxt  = 1'b0;
                    assert_nxt = 1'b0;
                end
                state[I_WRITE_RPLY]: trply_nxt = 1'b1;
                state[I_WRITE_WAIT]: if (!s_rdout) trply_nxt = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qslave2908.sv
// Bench for qslave2908: acts as a QBUS master and as the device register file behind the slave.
module tb_qslave2908;
    localparam int BASE_OFF = 'o12150;
    localparam int READ_LAT = 1;

    logic        clk = 1'b0;
    logic        RINIT_n = 1'b1;
    logic        RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0, RWTBT = 1'b0, RBS7 = 1'b0;
    logic        bus_master = 1'b0;
    logic [21:0] RADDR = '0;
    logic [15:0] RDAL = '0;
    logic        TRPLY, assert_data, DALst, DALbe, selected, reg_read, reg_write;
    logic [15:0] TDAL, reg_rdata, reg_wdata;
    logic [0:0]  reg_sel;
    logic [1:0]  reg_wbe;
    logic [10:0] fsm_state;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_read = 0, n_write = 0, read_cyc = 0, write_cyc = 0;
    logic [15:0] dev_mem [2];
    logic [15:0] exp_mem [2];
    logic [15:0] exp_q [$];

    qslave2908 #(.ADDR_BASE(13'o12150), .REG_BITS(1), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .RINIT_n(RINIT_n), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
        .RWTBT(RWTBT), .RBS7(RBS7), .RADDR(RADDR), .RDAL(RDAL), .bus_master(bus_master),
        .TRPLY(TRPLY), .TDAL(TDAL), .assert_data(assert_data), .DALst(DALst), .DALbe(DALbe),
        .selected(selected), .reg_sel(reg_sel), .reg_read(reg_read), .reg_write(reg_write),
        .reg_rdata(reg_rdata), .reg_wdata(reg_wdata), .reg_wbe(reg_wbe), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #25 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(50 * 60000);
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // Device register file behind the slave, plus strobe counters.
    always @(negedge clk) begin
        if (reg_read) begin
            n_read   <= n_read + 1;
            read_cyc <= cyc;
        end
        if (reg_write) begin
            n_write   <= n_write + 1;
            write_cyc <= cyc;
            if (reg_wbe[0]) dev_mem[reg_sel][7:0]  <= reg_wdata[7:0];
            if (reg_wbe[1]) dev_mem[reg_sel][15:8] <= reg_wdata[15:8];
        end
    end
    assign reg_rdata = dev_mem[reg_sel];

    // ---------------- reference model ----------------
    function automatic logic model_hit(logic [21:0] a, logic bs7, logic bm);
        int off;
        off = int'(a) % 8192;
        return bs7 && !bm && (off / 4 == BASE_OFF / 4);
    endfunction

    function automatic int model_idx(logic [21:0] a);
        return (int'(a) / 2) % 2;
    endfunction

    function automatic logic [1:0] model_wbe(logic [21:0] a, logic wtbt);
        if (!wtbt) return 2'b11;
        return (int'(a) % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_write(int idx, logic [15:0] d, logic [1:0] be);
        if (be[0]) exp_mem[idx][7:0]  = d[7:0];
        if (be[1]) exp_mem[idx][15:8] = d[15:8];
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_sync(input logic [21:0] a, input logic bs7);
        RADDR = a;
        RBS7  = bs7;
        step();
        RSYNC = 1'b1;
        repeat (5) step();
    endtask

    task automatic bus_end();
        RSYNC = 1'b0;
        repeat (4) step();
    endtask

    task automatic do_din(output logic rise, output logic [15:0] data, output int lat,
                          output logic drive_ok, output logic hold_ok, output int nread);
        int r0, t;
        r0 = n_read;
        RDIN = 1'b1;
        t = 0;
        while (!TRPLY && t < 20) begin step(); t++; end
        rise     = TRPLY;
        data     = TDAL;
        lat      = cyc - read_cyc;
        drive_ok = DALbe && assert_data && !DALst;
        RDIN = 1'b0;
        t = 0;
        while (TRPLY && t < 20) begin step(); t++; end
        hold_ok = !TRPLY && DALbe && assert_data;
        step();
        hold_ok = hold_ok && !DALbe && !assert_data;
        nread = n_read - r0;
    endtask

    task automatic do_dout(input logic [15:0] d, input logic wtbt, output logic rise,
                           output int lat, output logic rel_ok, output int nwrite);
        int w0, t;
        w0 = n_write;
        RDAL  = d;
        RWTBT = wtbt;
        RDOUT = 1'b1;
        t = 0;
        while (!TRPLY && t < 20) begin step(); t++; end
        rise = TRPLY;
        lat  = cyc - write_cyc;
        RDOUT = 1'b0;
        t = 0;
        while (TRPLY && t < 20) begin step(); t++; end
        rel_ok = !TRPLY;
        RWTBT  = 1'b0;
        nwrite = n_write - w0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #5 RINIT_n = 1'b0;
        repeat (2) step();
        n_checks++; if ({TRPLY, assert_data, DALst, DALbe, selected, reg_read, reg_write} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {TRPLY, assert_data, DALst, DALbe, selected, reg_read, reg_write}); end
        n_checks++; if ({TDAL, reg_wdata, reg_wbe, reg_sel} !== 35'b0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {TDAL, reg_wdata, reg_wbe, reg_sel}); end
        n_checks++; if (fsm_state !== 11'b1) begin
            n_fail++; $display("FAIL reset_state: got %b want idle", fsm_state); end
        @(negedge clk) RINIT_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_dati();
        logic rise, drv, hold; logic [15:0] d, e; int lat, nr;
        dev_mem[1] = 16'o123456; exp_mem[1] = 16'o123456;
        bus_sync(22'o17772152, 1'b1);
        n_checks++; if (selected !== 1'b1) begin n_fail++; $display("FAIL dati_selected: got %b want 1", selected); end
        n_checks++; if (reg_sel !== 1'b1) begin n_fail++; $display("FAIL dati_reg_sel: got %b want 1", reg_sel); end
        exp_q.push_back(exp_mem[1]);
        do_din(rise, d, lat, drv, hold, nr);
        e = exp_q.pop_front();
        n_checks++; if (rise !== 1'b1) begin n_fail++; $display("FAIL dati_trply: got %b want 1", rise); end
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL dati_tdal: got %o want %o", d, e); end
        n_checks++; if (lat != READ_LAT + 2) begin n_fail++; $display("FAIL dati_latency: got %0d want %0d", lat, READ_LAT + 2); end
        n_checks++; if (drv !== 1'b1) begin n_fail++; $display("FAIL dati_drive: got %b want 1", drv); end
        n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL dati_hold: got %b want 1", hold); end
        n_checks++; if (nr != 1) begin n_fail++; $display("FAIL dati_reads: got %0d want 1", nr); end
        bus_end();
        n_checks++; if (selected !== 1'b0) begin n_fail++; $display("FAIL dati_deselect: got %b want 0", selected); end
    endtask

    task automatic test_datob();
        logic rise, rel; int lat, nw;
        bus_sync(22'o17772153, 1'b1);
        do_dout(16'o177400, 1'b1, rise, lat, rel, nw);
        model_write(1, 16'o177400, 2'b10);
        n_checks++; if (rise !== 1'b1) begin n_fail++; $display("FAIL datob_trply: got %b want 1", rise); end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL datob_latency: got %0d want 1", lat); end
        n_checks++; if (reg_wdata !== 16'o177400) begin n_fail++; $display("FAIL datob_wdata: got %o want 177400", reg_wdata); end
        n_checks++; if (reg_wbe !== 2'b10) begin n_fail++; $display("FAIL datob_wbe: got %b want 10", reg_wbe); end
        n_checks++; if (nw != 1) begin n_fail++; $display("FAIL datob_writes: got %0d want 1", nw); end
        n_checks++; if (rel !== 1'b1) begin n_fail++; $display("FAIL datob_release: got %b want 1", rel); end
        bus_end();
        n_checks++; if (dev_mem[1] !== exp_mem[1]) begin n_fail++; $display("FAIL datob_mem: got %o want %o", dev_mem[1], exp_mem[1]); end
    endtask

    task automatic test_miss();
        logic rise, drv, hold; logic [15:0] d; int lat, nr;
        for (int k = 0; k < 2; k++) begin
            bus_master = (k == 1);
            bus_sync((k == 0) ? 22'o17772154 : 22'o17772150, 1'b1);
            n_checks++; if (selected !== 1'b0) begin n_fail++; $display("FAIL miss_selected%0d: got %b want 0", k, selected); end
            do_din(rise, d, lat, drv, hold, nr);
            n_checks++; if (rise !== 1'b0) begin n_fail++; $display("FAIL miss_trply%0d: got %b want 0", k, rise); end
            n_checks++; if (nr != 0) begin n_fail++; $display("FAIL miss_reads%0d: got %0d want 0", k, nr); end
            bus_end();
            bus_master = 1'b0;
        end
    endtask

    task automatic test_datio();
        logic rise, drv, hold, rel; logic [15:0] d, e, wd; int lat, nr, nw;
        bus_sync(22'o17772150, 1'b1);
        exp_q.push_back(exp_mem[0]);
        do_din(rise, d, lat, drv, hold, nr);
        e = exp_q.pop_front();
        n_checks++; if (rise !== 1'b1 || d !== e) begin n_fail++; $display("FAIL datio_read: got %b/%o want 1/%o", rise, d, e); end
        n_checks++; if (selected !== 1'b1) begin n_fail++; $display("FAIL datio_sel_mid: got %b want 1", selected); end
        wd = 16'($urandom);
        do_dout(wd, 1'b0, rise, lat, rel, nw);
        model_write(0, wd, 2'b11);
        n_checks++; if (rise !== 1'b1 || reg_wbe !== 2'b11) begin n_fail++; $display("FAIL datio_write: got %b/%b want 1/11", rise, reg_wbe); end
        n_checks++; if (nr != 1 || nw != 1) begin n_fail++; $display("FAIL datio_strobes: got %0d/%0d want 1/1", nr, nw); end
        n_checks++; if (selected !== 1'b1) begin n_fail++; $display("FAIL datio_sel_end: got %b want 1", selected); end
        bus_end();
    endtask

    task automatic test_abort();
        logic rise, drv, hold; logic [15:0] d, e; int t, lat, nr;
        bus_sync(22'o17772152, 1'b1);
        RDIN = 1'b1;
        t = 0;
        while (!TRPLY && t < 20) begin step(); t++; end
        n_checks++; if (TRPLY !== 1'b1) begin n_fail++; $display("FAIL abort_setup: got %b want 1", TRPLY); end
        RSYNC = 1'b0;
        repeat (2) step();
        n_checks++; if (TRPLY !== 1'b1) begin n_fail++; $display("FAIL abort_early: got %b want 1", TRPLY); end
        step();
        n_checks++; if ({TRPLY, DALbe, assert_data, selected, DALst} !== 5'b0) begin
            n_fail++; $display("FAIL abort_clear: got %b want 0", {TRPLY, DALbe, assert_data, selected, DALst}); end
        RDIN = 1'b0;
        repeat (4) step();
        bus_sync(22'o17772150, 1'b1);
        exp_q.push_back(exp_mem[0]);
        do_din(rise, d, lat, drv, hold, nr);
        e = exp_q.pop_front();
        n_checks++; if (rise !== 1'b1 || d !== e) begin n_fail++; $display("FAIL abort_after: got %b/%o want 1/%o", rise, d, e); end
        bus_end();
    endtask

    task automatic test_reset_mid_read();
        int t;
        bus_sync(22'o17772152, 1'b1);
        RDIN = 1'b1;
        t = 0;
        while (!TRPLY && t < 20) begin step(); t++; end
        n_checks++; if ({TRPLY, DALbe} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_setup: got %b want 11", {TRPLY, DALbe}); end
        #10 RINIT_n = 1'b0;
        #1;
        n_checks++; if ({TRPLY, assert_data, DALst, DALbe, selected, TDAL, reg_wdata, reg_wbe, reg_sel} !== 40'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", {TRPLY, assert_data, DALst, DALbe, selected, TDAL, reg_wdata, reg_wbe, reg_sel}); end
        RDIN = 1'b0;
        RSYNC = 1'b0;
        @(negedge clk) RINIT_n = 1'b1;
        repeat (3) step();
        n_checks++; if (fsm_state !== 11'b1) begin n_fail++; $display("FAIL rst_mid_state: got %b want idle", fsm_state); end
    endtask

    task automatic test_random();
        logic rise, drv, hold, rel, bs7, bm, h, wtbt; logic [15:0] d, e, wd; logic [1:0] be;
        logic [21:0] a; int lat, nr, nw, off, kind, idx;
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            bs7  = ($urandom_range(0, 7) != 0);
            bm   = (kind == 1);
            if (kind == 0) begin
                off = $urandom_range(0, 8191);
                if (off / 4 == BASE_OFF / 4) off = off ^ 'h40;
            end else begin
                off = BASE_OFF + $urandom_range(0, 3);
            end
            a = {9'($urandom), 13'(off)};
            h = model_hit(a, bs7, bm);
            idx = model_idx(a);
            bus_master = bm;
            bus_sync(a, bs7);
            n_checks++; if (selected !== h) begin n_fail++; $display("FAIL rnd_selected: addr %o got %b want %b", a, selected, h); end
            if (!h) begin
                do_din(rise, d, lat, drv, hold, nr);
                n_checks++; if (rise !== 1'b0 || nr != 0) begin n_fail++; $display("FAIL rnd_miss: addr %o got %b/%0d want 0/0", a, rise, nr); end
            end else begin
                for (int p = 0, n = $urandom_range(1, 3); p < n; p++) begin
                    if ($urandom_range(0, 1) == 0) begin
                        exp_q.push_back(exp_mem[idx]);
                        do_din(rise, d, lat, drv, hold, nr);
                        e = exp_q.pop_front();
                        n_checks++; if (rise !== 1'b1 || d !== e || lat != READ_LAT + 2) begin
                            n_fail++; $display("FAIL rnd_read: addr %o got %b/%o/%0d want 1/%o/%0d", a, rise, d, lat, e, READ_LAT + 2); end
                    end else begin
                        wd = 16'($urandom);
                        wtbt = $urandom_range(0, 1);
                        be = model_wbe(a, wtbt);
                        do_dout(wd, wtbt, rise, lat, rel, nw);
                        model_write(idx, wd, be);
                        n_checks++; if (rise !== 1'b1 || reg_wdata !== wd || reg_wbe !== be || nw != 1) begin
                            n_fail++; $display("FAIL rnd_write: addr %o got %b/%o/%b/%0d want 1/%o/%b/1", a, rise, reg_wdata, reg_wbe, nw, wd, be); end
                    end
                end
            end
            bus_end();
            bus_master = 1'b0;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            dev_mem[i] = 16'($urandom);
            exp_mem[i] = dev_mem[i];
        end
        test_reset();
        test_dati();
        test_datob();
        test_miss();
        test_datio();
        test_abort();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qslave2908.md
# qslave2908

Bus-slave (responder) logic for the QBUS when Am2908 transceivers sit between the FPGA and the bus. It decodes I/O-page addresses latched by the Am2908 receive registers and runs the slave side of DATI, DATO(B) and DATIO(B) cycles. It issues one-clock read and write strobes to a small device register file, sequences the Am2908 strobe and enable for read data, and generates TRPLY. It is the counterpart to the DMA bus-master sequencer and shares the DALst/DALbe/assert_data transceiver controls with it through a board-level mux selected by `bus_master`.

## Interface
- ADDR_BASE, 13'o12150, I/O-page offset of register 0 (full address 17772150).
- REG_BITS, 1, log2 of the number of word registers decoded.
- READ_LAT, 1, clocks (≥1) from the rise of reg_read to the sampling of reg_rdata.

- clk  in  1  20 MHz system clock
- RINIT_n  in  1  asynchronous active-low reset
- RSYNC, RDIN, RDOUT, RWTBT  in  1 each  received bus controls, asynchronous
- RBS7  in  1  I/O-page select, latched with the address
- RADDR  in  22  address latched by the Am2908s on the RSYNC leading edge, stable while RSYNC is high
- RDAL  in  16  live received DAL (write data)
- bus_master  in  1  our own master owns the bus; suppresses decode
- TRPLY  out  1  reply to the bus
- TDAL  out  16  read data toward the Am2908s
- assert_data, DALst, DALbe  out  1 each  Am2908 data-path control, strobe and bus enable
- selected  out  1  this device was addressed in the current SYNC
- reg_sel  out  REG_BITS  word index, RADDR[REG_BITS:1]
- reg_read, reg_write  out  1  one-clock strobes
- reg_rdata  in  16  register read data
- reg_wdata  out  16  captured write data
- reg_wbe  out  2  byte enables {hi,lo}

## Operation
- RSYNC, RDIN, RDOUT and RWTBT each pass through a 2-flop synchronizer, giving sRSYNC, sRDIN, sRDOUT and sRWTBT. The synchronizers clear asynchronously on reset.
- The state machine is one-hot with these states: IDLE, DECODE, IGNORE, SELECTED, READ_FETCH, READ_SETUP, READ_DRIVE, READ_RPLY, READ_HOLD, WRITE_RPLY and WRITE_WAIT.
- IDLE: if sRSYNC is high and bus_master is low, go to DECODE.
- DECODE: a hit requires RBS7 high and RADDR[12:REG_BITS+1] equal to ADDR_BASE[12:REG_BITS+1]; RADDR[21:13] is ignored.
  - On a hit, load reg_sel, set selected and go to SELECTED.
  - On a miss, go to IGNORE.
- IGNORE: wait for sRSYNC low, then go to IDLE.
- SELECTED: sRDIN has priority over sRDOUT.
  - sRDIN high: go to READ_FETCH.
  - Otherwise sRDOUT high: go to WRITE_RPLY.
  - sRSYNC low: clear selected and go to IDLE.
- Read path:
  - READ_FETCH: reg_read is high for its first clock only. The state lasts READ_LAT clocks. On exit, TDAL ← reg_rdata and assert_data ← 1.
  - READ_SETUP: DALst ← 1 for one clock.
  - READ_DRIVE: DALst ← 0, DALbe ← 1.
  - READ_RPLY: TRPLY ← 1. When sRDIN goes low, TRPLY ← 0 and go to READ_HOLD.
  - READ_HOLD: DALbe ← 0 and assert_data ← 0, then return to SELECTED.
- Write path:
  - On the edge leaving SELECTED: reg_wdata ← RDAL, reg_write ← 1.
  - reg_wbe is 2'b11 when sRWTBT is low. When sRWTBT is high it is 2'b10 if RADDR[0] is 1, else 2'b01.
  - WRITE_RPLY: reg_write ← 0, TRPLY ← 1.
  - WRITE_WAIT: when sRDOUT goes low, TRPLY ← 0 and return to SELECTED.
- DATIO(B) is handled by looping back to SELECTED: any number of DIN/DOUT phases can occur inside one SYNC.
- Abort: if sRSYNC goes low in any state other than IDLE or IGNORE, then at the next edge:
  - TRPLY, DALst, DALbe, assert_data and selected clear to 0;
  - the state returns to IDLE;
  - strobes already issued are not retracted.

## Timing
- Reset (asynchronous): the state is IDLE and every output is 0, including TDAL, reg_wdata, reg_wbe and reg_sel.
- Edge E0 is the first edge at which SELECTED sees sRDIN high. From there:
  - reg_read is high during E0..E1;
  - reg_rdata is sampled at E(READ_LAT);
  - DALst is high during E(L)..E(L+1);
  - DALbe rises at E(L+1);
  - TRPLY rises at E(L+2), so data is on the bus 50 ns before the reply;
  - where L is READ_LAT.
- Read release: TRPLY falls at the first edge that sees sRDIN low. DALbe and assert_data fall one edge later (50 ns data hold).
- Write: edge E0 sees sRDOUT high. Data is captured and reg_write rises at E0; TRPLY rises at E1. TRPLY falls at the first edge that sees sRDOUT low.
- Synchronizer delay adds 2 clocks to every bus-input response.

## Test plan
- Reset: hold RINIT_n low mid-read, with TRPLY and DALbe high -> all outputs go to 0 immediately, with no clock edge needed; after release the state is IDLE.
- DATI hit, READ_LAT = 1: RBS7=1, RADDR=22'o17772152, RSYNC then RDIN, reg_rdata=16'o123456 -> reg_sel=1, one reg_read pulse, TDAL=16'o123456, TRPLY rises 3 edges after E0; drop RDIN -> TRPLY low, then DALbe low one clock later.
- DATOB high byte: RADDR=22'o17772153, RWTBT=1, RDAL=16'o177400 -> reg_wbe=2'b10, reg_wdata=16'o177400, exactly one reg_write pulse, TRPLY follows one clock later.
- Miss and self-cycle:
  - RADDR=22'o17772154 -> selected=0, no strobes, TRPLY never asserts.
  - Hit address with bus_master=1 -> same result.
- DATIO: one SYNC carrying DIN then DOUT to 22'o17772150 -> one reg_read and one reg_write, each replied, selected stays 1 throughout.
- Abort: drop RSYNC while in READ_RPLY with RDIN still high -> TRPLY, DALbe, assert_data and selected are all 0 at the next edge; a following cycle decodes normally.
